bus_uart_tx: RTL
================

// Module: bus_uart_tx
// PURPOSE
// - Memory-mapped UART transmitter; a responder on the core data bus (bus_re/bus_we/bus_addr/bus_wdata/bus_rdata).
// - Core writes bytes into a TX FIFO; an 8N1 serializer drains the FIFO onto uart_tx at a programmable bit period.
// - Zero wait states: the single-cycle core cannot stall, so reads are combinational and writes commit at the clock edge.
// PARAMETERS
// BASE_ADDR   32'h1000_0000  16-byte window base; hit = (bus_addr[31:4] == BASE_ADDR[31:4])
// CLK_DIV     16'd434        reset value of DIV (clock cycles per UART bit)
// FIFO_DEPTH  8              TX FIFO entries; power of two, 2..128
// PORTS
// clk        in   1   system clock
// rst_n      in   1   reset; synchronous, active-low
// bus_re     in   1   read strobe
// bus_we     in   4   byte-lane write enables; lane i = bus_wdata[8i+7:8i]
// bus_addr   in   32  byte address; [3:2] selects the register, [1:0] ignored
// bus_wdata  in   32  write data
// bus_rdata  out  32  read data; combinational; 0 when bus_re=0 or no hit
// uart_tx    out  1   serial output; idle high
// irq        out  1   level interrupt = CTRL.ie & STATUS.empty & !busy
// BEHAVIOUR
// - Register map (offset from BASE_ADDR):
//   0x0 TXDATA  W: any write with bus_we[0]=1 pushes bus_wdata[7:0]; reads 0.
//   0x4 STATUS  R: [0] busy (serializer not IDLE), [1] full, [2] empty, [3] ovf (sticky), [15:8] count, rest 0.
//               W: bus_we[0] & bus_wdata[3] clears ovf (W1C); other bits ignored.
//   0x8 DIV     R/W [15:0] honour bus_we[1:0]; [31:16] read 0. A written value of 0 acts as 1.
//   0xC CTRL    R/W [0] ie under bus_we[0]; other bits read 0.
// - Writes with no hit or bus_we=0 have no effect. A write and a read in the same cycle are both legal; the read returns pre-edge values.
// - Reset (rst_n=0 at posedge): uart_tx=1, irq=0, FIFO empty (count 0), ovf=0, ie=0, DIV=CLK_DIV, FSM=IDLE, baud counter=0.
// - FIFO: the push is accepted when count<FIFO_DEPTH or a pop occurs in the same cycle. Otherwise the byte is dropped and ovf is set.
// - FIFO pointers wrap modulo FIFO_DEPTH. Count has $clog2(FIFO_DEPTH)+1 bits.
// - FSM IDLE/START/DATA/STOP; the baud counter counts div_l-1 down to 0; every state holds exactly div_l cycles.
//   IDLE: uart_tx=1. If the FIFO is non-empty: pop into shift reg, latch div_l=max(DIV,1), go to START.
//   START: uart_tx=0. Then DATA with bit index 0.
//   DATA: uart_tx=shift[0], LSB first. Shift at the end of each bit. After bit 7, go to STOP.
//   STOP: uart_tx=1. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap, re-latch div_l). Otherwise go to IDLE.
// - uart_tx is registered. For a write at edge N to an idle block: pop at edge N+1, uart_tx=0 from edge N+1.
// - DIV writes during a frame take effect at the next frame's START only.
// - Reset mid-frame aborts the frame: uart_tx=1 on the reset edge and FIFO contents are lost.
// - busy=0 only in IDLE. empty and full are derived from count.
// TESTING
// - Reset, then read 0x4/0x8/0xC -> 0x0000_0004 / 0x0000_01B2 / 0x0; uart_tx=1, irq=0.
// - DIV=4, write 0x55 -> uart_tx low 4 cycles, bits 1,0,1,0,1,0,1,0 at 4 cycles each, high stop 4; frame 40 cycles; busy=1 throughout.
// - DIV=100, write 0x01..0x0A on 10 consecutive cycles -> 0x0A dropped, STATUS=0x0000_080B (count 8, ovf, full, busy).
//   Frames 0x01..0x09 transmit in order. A W1C write of 0x8 to 0x4 clears ovf.
// - DIV=2, write 0xA0 then 0x0F -> two frames of 20 cycles back-to-back, no idle cycles; then irq=1 if ie=1.
// - Write DIV with bus_we=4'b0001, wdata=0x0000_0003 from 0x01B2 -> reads 0x0000_0103. Read at BASE_ADDR+0x10 -> 0.
// - Assert rst_n=0 for one edge during DATA bit 3 -> uart_tx=1 and STATUS=0x4 next cycle, DIV=0x1B2.

Source files
------------

// File: rtl/bus_uart_tx.sv
// rtl/bus_uart_tx.sv - memory-mapped 8N1 UART transmitter with a TX FIFO
// Zero-wait-state bus responder: combinational reads, writes commit at the clock edge.
module bus_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [15:0] CLK_DIV    = 16'd434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_re,
  input  logic [3:0]  bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        uart_tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          ie_q, ie_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   div_l_q, div_l_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  state_t        state_q, state_d;

  logic        hit, push_req, push_ok, pop, clr_ovf;
  logic [1:0]  sel;
  logic [15:0] div_eff;
  logic        baud_last, fifo_empty, fifo_full, busy;
  logic [7:0]  count8;
  logic        unused_bits;

  assign hit        = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign sel        = bus_addr[3:2];
  assign push_req   = hit && (sel == 2'd0) && bus_we[0];
  assign clr_ovf    = hit && (sel == 2'd1) && bus_we[0] && bus_wdata[3];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign busy       = (state_q != S_IDLE);
  assign baud_last  = (baud_q == 16'd0);
  assign div_eff    = (div_q == 16'd0) ? 16'd1 : div_q;
  assign count8     = 8'(count_q);
  assign unused_bits = &{1'b0, bus_we[3:2], bus_wdata[31:16], bus_addr[1:0]};

  // Serializer next-state; pop is the only path that removes FIFO entries.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    div_l_d   = div_l_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        pop  = !fifo_empty;
      end
      S_START: begin
        if (baud_last) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          baud_d    = div_l_q - 16'd1;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = div_l_q - 16'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (fifo_empty) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end else begin
            pop = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (pop) begin
      state_d = S_START;
      shift_d = mem_q[rd_ptr_q];
      div_l_d = div_eff;
      baud_d  = div_eff - 16'd1;
      tx_d    = 1'b0;
    end
  end

  always_comb begin
    push_ok  = push_req && (!fifo_full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (push_req && !push_ok) ovf_d = 1'b1;
    else if (clr_ovf)         ovf_d = 1'b0;
    div_d = div_q;
    if (hit && sel == 2'd2) begin
      if (bus_we[0]) div_d[7:0]  = bus_wdata[7:0];
      if (bus_we[1]) div_d[15:8] = bus_wdata[15:8];
    end
    ie_d = ie_q;
    if (hit && sel == 2'd3 && bus_we[0]) ie_d = bus_wdata[0];
  end

  always_comb begin
    bus_rdata = 32'h0;
    if (bus_re && hit) begin
      case (sel)
        2'd1:    bus_rdata = {16'h0, count8, 4'h0, ovf_q, fifo_empty, fifo_full, busy};
        2'd2:    bus_rdata = {16'h0, div_q};
        2'd3:    bus_rdata = {31'h0, ie_q};
        default: bus_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h0;
      div_l_q   <= 16'd1;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ie_q      <= 1'b0;
      div_q     <= CLK_DIV;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      div_l_q   <= div_l_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ie_q      <= ie_d;
      div_q     <= div_d;
    end
  end

  assign uart_tx = tx_q;
  assign irq     = ie_q && fifo_empty && !busy;

endmodule
